// File: rtl/key_bounce_gen.sv
// key_bounce_gen: mechanical key emulator driving one press/release cycle with LFSR bounce
module key_bounce_gen #(
  parameter logic [21:0] PRE_CYC    = 22'd50_000,
  parameter logic [21:0] BOUNCE_CYC = 22'd500_000,
  parameter logic [21:0] HOLD_CYC   = 22'd1_500_000,
  parameter logic [21:0] REL_CYC    = 22'd500_000,
  parameter logic [21:0] POST_CYC   = 22'd450_000,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       repeat_en,
  input  logic       abort,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] press_cnt
);
  typedef enum logic [2:0] {IDLE, PRE, BOUNCE_F, HOLD, BOUNCE_R, POST} state_t;
  state_t      state, state_nxt;
  logic [21:0] cnt, plen;
  logic [15:0] lfsr, lfsr_nxt;
  logic        last, bounce_nxt;
  // phase length of the current state, end-of-phase flag and LFSR step
  always_comb begin
    plen = state == PRE      ? PRE_CYC    :
           state == BOUNCE_F ? BOUNCE_CYC :
           state == HOLD     ? HOLD_CYC   :
           state == BOUNCE_R ? REL_CYC    :
           state == POST     ? POST_CYC   : 22'd1;
    last = cnt == plen - 22'd1;
    lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    bounce_nxt = state_nxt == BOUNCE_F || state_nxt == BOUNCE_R;
    busy = state != IDLE;
  end
  // next-state logic; abort wins over everything, start only counts in IDLE
  always_comb begin
    state_nxt = state;
    if (abort)
      state_nxt = IDLE;
    else
      case (state)
        IDLE:     state_nxt = start ? PRE : IDLE;
        PRE:      state_nxt = last ? BOUNCE_F : PRE;
        BOUNCE_F: state_nxt = last ? HOLD : BOUNCE_F;
        HOLD:     state_nxt = last ? BOUNCE_R : HOLD;
        BOUNCE_R: state_nxt = last ? POST : BOUNCE_R;
        POST:     state_nxt = last ? (repeat_en ? PRE : IDLE) : POST;
        default:  state_nxt = IDLE;
      endcase
  end
  // state, phase counter, LFSR and registered outputs; key_out follows the state being entered
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lfsr      <= SEED;
      key_out   <= 1'b1;
      done      <= 1'b0;
      press_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= (state_nxt != state || state == IDLE) ? '0 : cnt + 22'd1;
      if (bounce_nxt) lfsr <= lfsr_nxt;
      key_out <= bounce_nxt ? lfsr_nxt[0] : state_nxt != HOLD;
      done    <= !abort && state == POST && last;
      if (state == HOLD && cnt == '0) press_cnt <= press_cnt + 8'd1;
    end
  end
endmodule
